// File: rtl/systolic_feeder.sv
// Input-side feeder for an N x N systolic array: buffers weight rows and
// activation vectors, loads weights down the columns and skews activations across the rows.
module systolic_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_data,
   input  logic                    in_kind,
   input  logic                    in_last,
   output logic [N*DATA_WIDTH-1:0] top_out,
   output logic [N*DATA_WIDTH-1:0] left_out,
   output logic [N-1:0]            left_valid,
   output logic                    weight_WE,
   output logic                    mux_ctrl,
   output logic                    done
);

   localparam int VW = N * DATA_WIDTH;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW:0]   DEPTH_COUNT = (PW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_COUNT  = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DRAIN} state_t;

   state_t state, next_state;

   logic [VW-1:0]         fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_kind;
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           fifo_count;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop;
   logic [VW-1:0]         head_data;
   logic                  head_kind, head_last;

   logic [CW-1:0]         count;
   logic [VW-1:0]         held_row;
   logic [VW-1:0]         inject_data;
   logic                  inject_valid;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == DEPTH_COUNT);
   assign in_ready   = !reset && !fifo_full;
   assign push       = in_valid && in_ready;
   assign head_data  = fifo_data[rd_ptr];
   assign head_kind  = fifo_kind[rd_ptr];
   assign head_last  = fifo_last[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= in_data;
         fifo_kind[wr_ptr] <= in_kind;
         fifo_last[wr_ptr] <= in_last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         held_row <= '0;
         done     <= 1'b0;
      end else begin
         state <= next_state;
         done  <= (state == DRAIN) && (count == LAST_COUNT);
         if (next_state != state)
            count <= '0;
         else if ((state == WLOAD && pop) || state == DRAIN)
            count <= count + 1'b1;
         if (state == WLOAD && pop)
            held_row <= head_data;
      end
   end

   // A weight row is driven in the same cycle it is popped; held_row covers stalls.
   always_comb begin
      next_state   = state;
      pop          = 1'b0;
      inject_valid = 1'b0;
      inject_data  = '0;
      top_out      = '0;
      weight_WE    = 1'b0;
      mux_ctrl     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty)
               next_state = head_kind ? WLOAD : STREAM;
         end
         WLOAD: begin
            top_out = held_row;
            if (!fifo_empty) begin
               pop     = 1'b1;
               top_out = head_data;
               if (count == LAST_COUNT) begin
                  weight_WE  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         STREAM: begin
            mux_ctrl = 1'b1;
            if (!fifo_empty) begin
               pop          = 1'b1;
               inject_valid = 1'b1;
               inject_data  = head_data;
               if (head_last)
                  next_state = DRAIN;
            end
         end
         DRAIN: begin
            mux_ctrl = 1'b1;
            if (count == LAST_COUNT)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Lane i is a private shift register of depth i+1, forming the diagonal wavefront.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] pipe_data [i+1];
      logic [i:0]            pipe_valid;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int k = 0; k <= i; k++)
               pipe_data[k] <= '0;
            pipe_valid <= '0;
         end else begin
            pipe_data[0]  <= inject_data[i*DATA_WIDTH +: DATA_WIDTH];
            pipe_valid[0] <= inject_valid;
            for (int k = 1; k <= i; k++) begin
               pipe_data[k]  <= pipe_data[k-1];
               pipe_valid[k] <= pipe_valid[k-1];
            end
         end
      end

      assign left_out[i*DATA_WIDTH +: DATA_WIDTH] = pipe_data[i];
      assign left_valid[i]                        = pipe_valid[i];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed scenarios plus random traffic,
// all checked against a queue-based transaction model of the feeder.
module tb_systolic_feeder;

   localparam int DW         = 16;
   localparam int N          = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int VW         = N * DW;
   localparam int BW         = 2 * VW + N + 4;
   localparam int M_IDLE     = 0;
   localparam int M_WLOAD    = 1;
   localparam int M_STREAM   = 2;
   localparam int M_DRAIN    = 3;

   typedef struct packed {
      logic [VW-1:0] data;
      logic          kind;
      logic          last;
   } entry_t;

   typedef struct packed {
      logic [VW-1:0] data;
      logic          valid;
   } inj_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [VW-1:0] in_data = '0;
   logic          in_kind = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [VW-1:0] top_out;
   logic [VW-1:0] left_out;
   logic [N-1:0]  left_valid;
   logic          weight_WE;
   logic          mux_ctrl;
   logic          done;

   systolic_feeder #(.DATA_WIDTH(DW), .N(N), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_kind    (in_kind),
      .in_last    (in_last),
      .top_out    (top_out),
      .left_out   (left_out),
      .left_valid (left_valid),
      .weight_WE  (weight_WE),
      .mux_ctrl   (mux_ctrl),
      .done       (done)
   );

   always #5 clk = ~clk;

   wire [BW-1:0] obs_bus = {in_ready, top_out, left_out, left_valid, weight_WE, mux_ctrl, done};

   entry_t        fifo_m [$];
   entry_t        pending [$];
   inj_t          hist [$];
   int            mode;
   int            rows_loaded;
   int            bubbles;
   bit            done_m;
   logic [VW-1:0] last_row;

   logic          exp_ready, exp_we, exp_mux, exp_done;
   logic [VW-1:0] exp_top, exp_left;
   logic [N-1:0]  exp_lvalid;
   logic [BW-1:0] exp_bus;

   int n_checks = 0;
   int n_fail   = 0;

   // Outputs the spec implies for the current cycle, from the abstract state.
   task automatic model_eval();
      inj_t h;
      exp_ready = !reset && (fifo_m.size() < FIFO_DEPTH);
      exp_top   = '0;
      exp_we    = 1'b0;
      if (mode == M_WLOAD) begin
         if (fifo_m.size() > 0) begin
            exp_top = fifo_m[0].data;
            exp_we  = (rows_loaded == N - 1);
         end else begin
            exp_top = last_row;
         end
      end
      exp_mux = (mode == M_STREAM) || (mode == M_DRAIN);
      for (int i = 0; i < N; i++) begin
         h = hist[hist.size() - 1 - i];
         exp_left[i*DW +: DW] = h.data[i*DW +: DW];
         exp_lvalid[i]        = h.valid;
      end
      exp_done = done_m;
      exp_bus  = {exp_ready, exp_top, exp_left, exp_lvalid, exp_we, exp_mux, exp_done};
   endtask

   task automatic model_reset();
      inj_t b;
      b.data  = '0;
      b.valid = 1'b0;
      fifo_m.delete();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(b);
      mode        = M_IDLE;
      rows_loaded = 0;
      bubbles     = 0;
      done_m      = 1'b0;
      last_row    = '0;
   endtask

   task automatic model_advance();
      entry_t h, e;
      inj_t   inj;
      bit     have, do_push;
      do_push = in_valid && exp_ready;
      if (reset) begin
         model_reset();
         return;
      end
      have = (fifo_m.size() > 0);
      h    = have ? fifo_m[0] : '0;
      inj.data  = '0;
      inj.valid = 1'b0;
      done_m    = 1'b0;
      case (mode)
         M_IDLE: if (have) mode = h.kind ? M_WLOAD : M_STREAM;
         M_WLOAD: if (have) begin
            e = fifo_m.pop_front();
            last_row = h.data;
            if (rows_loaded == N - 1) begin
               rows_loaded = 0;
               mode = M_IDLE;
            end else begin
               rows_loaded++;
            end
         end
         M_STREAM: if (have) begin
            e = fifo_m.pop_front();
            inj.data  = h.data;
            inj.valid = 1'b1;
            if (h.last) begin
               mode = M_DRAIN;
               bubbles = 0;
            end
         end
         default: begin
            if (bubbles == N - 1) begin
               done_m = 1'b1;
               mode = M_IDLE;
            end else begin
               bubbles++;
            end
         end
      endcase
      hist.push_back(inj);
      inj = hist.pop_front();
      if (do_push) begin
         e.data = in_data;
         e.kind = in_kind;
         e.last = in_last;
         fifo_m.push_back(e);
         e = pending.pop_front();
      end
   endtask

   task automatic drive_cycle(input bit want, input bit rst);
      reset = rst;
      if (want && pending.size() > 0) begin
         in_valid = 1'b1;
         in_data  = pending[0].data;
         in_kind  = pending[0].kind;
         in_last  = pending[0].last;
      end else begin
         in_valid = 1'b0;
         in_data  = '0;
         in_kind  = 1'b0;
         in_last  = 1'b0;
      end
      #1;
      model_eval();
   endtask

   task automatic tick();
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive_cycle(1'b0, 1'b0);
         tick();
      end
   endtask

   function automatic entry_t make_entry(input logic [VW-1:0] d, input logic k, input logic l);
      entry_t e;
      e.data = d;
      e.kind = k;
      e.last = l;
      return e;
   endfunction

   task automatic test_reset();
      drive_cycle(1'b0, 1'b1);
      tick();
      drive_cycle(1'b0, 1'b1);
      n_checks++;
      if (obs_bus !== {BW{1'b0}}) begin
         n_fail++;
         $display("[TB] FAIL reset_hold: got %h expected all zero", obs_bus);
      end
      tick();
      drive_cycle(1'b0, 1'b0);
      n_checks++;
      if (obs_bus !== exp_bus || in_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got %h expected %h", obs_bus, exp_bus);
      end
      tick();
   endtask

   task automatic test_weight_load();
      logic [9:0]    we_seq;
      logic [DW-1:0] rv;
      we_seq = '0;
      for (int r = 1; r <= N; r++) begin
         rv = DW'(r);
         pending.push_back(make_entry({N{rv}}, 1'b1, 1'b0));
      end
      for (int t = 0; t < 10; t++) begin
         drive_cycle(1'b1, 1'b0);
         we_seq[t] = weight_WE;
         n_checks++;
         if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL weight_load cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         n_checks++;
         if (mux_ctrl !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL weight_mux cycle %0d: got %b expected 0", t, mux_ctrl);
         end
         if (t >= 2 && t <= 5) begin
            rv = DW'(t - 1);
            n_checks++;
            if (top_out !== {N{rv}}) begin
               n_fail++;
               $display("[TB] FAIL weight_row cycle %0d: got %h expected %h", t, top_out, {N{rv}});
            end
         end
         tick();
      end
      n_checks++;
      if (we_seq !== 10'b0000100000) begin
         n_fail++;
         $display("[TB] FAIL weight_we_timing: got %b expected %b", we_seq, 10'b0000100000);
      end
   endtask

   task automatic test_skew();
      logic [VW-1:0] v;
      logic [DW-1:0] cap [N];
      int            first_v [N];
      int            done_t, done_n;
      for (int i = 0; i < N; i++) begin
         v[i*DW +: DW] = DW'(16'h10 + i);
         first_v[i] = -1;
         cap[i] = '0;
      end
      done_t = -1;
      done_n = 0;
      pending.push_back(make_entry(v, 1'b0, 1'b1));
      for (int t = 0; t < 12; t++) begin
         drive_cycle(1'b1, 1'b0);
         n_checks++;
         if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL skew cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         for (int i = 0; i < N; i++)
            if (left_valid[i] === 1'b1 && first_v[i] < 0) begin
               first_v[i] = t;
               cap[i] = left_out[i*DW +: DW];
            end
         if (done === 1'b1) begin
            done_n++;
            if (done_t < 0) done_t = t;
         end
         tick();
      end
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (first_v[i] != 3 + i || cap[i] !== DW'(16'h10 + i)) begin
            n_fail++;
            $display("[TB] FAIL skew_lane%0d: got cycle %0d data %h expected cycle %0d data %h",
                     i, first_v[i], cap[i], 3 + i, DW'(16'h10 + i));
         end
      end
      n_checks++;
      if (done_t != 3 + N || done_n != 1) begin
         n_fail++;
         $display("[TB] FAIL skew_done: got cycle %0d count %0d expected cycle %0d count 1",
                  done_t, done_n, 3 + N);
      end
   endtask

   task automatic test_back_to_back();
      int acc, drop_t, rise_t;
      acc    = 0;
      drop_t = -1;
      rise_t = -1;
      pending.push_back(make_entry(VW'({$urandom(), $urandom()}), 1'b0, 1'b1));
      for (int t = 0; t < 30; t++) begin
         if (t == 3)
            for (int k = 0; k < 6; k++)
               pending.push_back(make_entry(VW'({$urandom(), $urandom()}), 1'b0, k == 5));
         drive_cycle((t == 0) || (t >= 3), 1'b0);
         n_checks++;
         if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL backpressure cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         if (t >= 3) begin
            if (drop_t < 0 && in_ready === 1'b0) begin
               drop_t = t;
               n_checks++;
               if (acc != FIFO_DEPTH) begin
                  n_fail++;
                  $display("[TB] FAIL backpressure_accepted: got %0d expected %0d", acc, FIFO_DEPTH);
               end
            end else if (drop_t >= 0 && rise_t < 0 && in_ready === 1'b1) begin
               rise_t = t;
            end
            if (drop_t < 0 && in_valid && in_ready === 1'b1) acc++;
         end
         tick();
      end
      n_checks++;
      if (drop_t != 7 || rise_t != 9) begin
         n_fail++;
         $display("[TB] FAIL backpressure_ready: got drop %0d rise %0d expected drop 7 rise 9", drop_t, rise_t);
      end
   endtask

   task automatic test_starvation();
      logic [4:0]  pat;
      logic [13:0] l0, l3;
      int          gi;
      pat = 5'b10101;
      l0  = '0;
      l3  = '0;
      for (int k = 0; k < 3; k++)
         pending.push_back(make_entry(VW'({$urandom(), $urandom()}), 1'b0, k == 2));
      for (int t = 0; t < 14; t++) begin
         drive_cycle((t < 5) ? pat[t] : 1'b0, 1'b0);
         n_checks++;
         if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL starvation cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         l0[t] = left_valid[0];
         l3[t] = left_valid[N-1];
         if (t >= 5 && t < 5 + N) begin
            gi = t - 5;
            n_checks++;
            if (left_valid[gi] !== 1'b0 || left_out[gi*DW +: DW] !== '0) begin
               n_fail++;
               $display("[TB] FAIL starvation_bubble lane %0d: got valid %b data %h expected 0 0",
                        gi, left_valid[gi], left_out[gi*DW +: DW]);
            end
         end
         tick();
      end
      n_checks++;
      if (l0 !== 14'h0058 || l3 !== 14'h02c0) begin
         n_fail++;
         $display("[TB] FAIL starvation_pattern: got %h %h expected 0058 02c0", l0, l3);
      end
   endtask

   task automatic test_reset_midstream();
      for (int k = 0; k < 3; k++)
         pending.push_back(make_entry(VW'({$urandom(), $urandom()}), 1'b0, 1'b0));
      for (int t = 0; t < 4; t++) begin
         drive_cycle(1'b1, 1'b0);
         n_checks++;
         if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL midreset_pre cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         tick();
      end
      drive_cycle(1'b0, 1'b1);
      n_checks++;
      if (obs_bus !== exp_bus || in_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_during: got %h expected %h", obs_bus, exp_bus);
      end
      tick();
      for (int t = 0; t < 10; t++) begin
         drive_cycle(1'b0, 1'b0);
         n_checks++;
         if (obs_bus !== {1'b1, {(BW-1){1'b0}}} || obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL midreset_after cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         tick();
      end
      pending.delete();
   endtask

   task automatic test_random_traffic();
      int len, quiet, t;
      bit finished;
      for (int j = 0; j < 10; j++) begin
         if ($urandom_range(0, 1) == 1) begin
            for (int r = 0; r < N; r++)
               pending.push_back(make_entry(VW'({$urandom(), $urandom()}),
                                            (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                                            1'($urandom_range(0, 1))));
         end else begin
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++)
               pending.push_back(make_entry(VW'({$urandom(), $urandom()}),
                                            (k == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
                                            k == len - 1));
         end
      end
      quiet    = 0;
      finished = 1'b0;
      t        = 0;
      while (!finished && t < 800) begin
         drive_cycle($urandom_range(0, 3) != 0, 1'b0);
         n_checks++;
         if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("[TB] FAIL random cycle %0d: got %h expected %h", t, obs_bus, exp_bus);
         end
         tick();
         if (pending.size() == 0 && fifo_m.size() == 0 && mode == M_IDLE && !done_m) quiet++;
         else quiet = 0;
         if (quiet >= N + 2) finished = 1'b1;
         t++;
      end
      if (!finished) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL random_timeout: got %0d cycles without draining, expected drain", t);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      idle_cycles(3);
      test_weight_load();
      idle_cycles(3);
      test_skew();
      idle_cycles(3);
      test_back_to_back();
      idle_cycles(3);
      test_starvation();
      idle_cycles(3);
      test_reset_midstream();
      idle_cycles(3);
      test_random_traffic();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DATA_WIDTH, 16, bit width of one lane element.
REQ-002 Parameter N, 4, array dimension (number of rows and columns).
REQ-003 Parameter FIFO_DEPTH, 4, input vector FIFO entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream vector valid.
REQ-007 in_ready  output  1  feeder can accept a vector this cycle.
REQ-008 in_data  input  N*DATA_WIDTH  vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_kind  input  1  0 = activation vector, 1 = weight row.
REQ-010 in_last  input  1  marks final activation vector of a stream.
REQ-011 top_out  output  N*DATA_WIDTH  column-top data into array (weights or zero partial-sum seed).
REQ-012 left_out  output  N*DATA_WIDTH  skewed activations into array row left edges.
REQ-013 left_valid  output  N  per-lane valid for left_out.
REQ-014 weight_WE  output  1  array-wide weight latch enable.
REQ-015 mux_ctrl  output  1  array-wide select: 0 = pass in_top down, 1 = accumulate.
REQ-016 done  output  1  one-cycle pulse when a stream has fully drained.

Function
REQ-017 The feeder SHALL buffer {in_data, in_kind, in_last} in a FIFO; push when in_valid && in_ready; in_ready SHALL equal !full (registered-state derived, not combinationally dependent on pop).
REQ-018 The feeder SHALL implement states IDLE, WLOAD, STREAM, DRAIN.
REQ-019 IDLE: on FIFO non-empty, head in_kind=1 -> WLOAD, head in_kind=0 -> STREAM; no pop in the transition cycle.
REQ-020 WLOAD SHALL pop exactly N entries on N consecutive non-empty cycles (kind bits ignored), drive each popped row on top_out, mux_ctrl=0, left_valid=0.
REQ-021 WLOAD SHALL stall (top_out held, no count advance, weight_WE=0) while FIFO empty.
REQ-022 weight_WE SHALL be 1 only in the cycle the N-th row is driven; first popped row thus lands in array row N-1, last popped row in array row 0; then -> IDLE.
REQ-023 STREAM: mux_ctrl=1, top_out=0; each cycle pop one entry if non-empty and present it to the skew network with valid=1, else inject a bubble (data 0, valid 0).
REQ-024 Skew network: lane i of left_out/left_valid SHALL equal lane i of the vector injected i+1 cycles earlier (lane 0 latency 1, lane N-1 latency N).
REQ-025 On popping an entry with in_last=1, STREAM -> DRAIN; in_kind is ignored in STREAM.
REQ-026 DRAIN SHALL inject bubbles for N cycles, then assert done for one cycle and return to IDLE; no pops in DRAIN.
REQ-027 Simultaneous push and pop on a full FIFO SHALL NOT occur (in_ready=0 when full); push and pop in the same cycle otherwise SHALL both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-028 Outside STREAM/DRAIN the skew network SHALL carry only bubbles; outside WLOAD top_out=0 and weight_WE=0.

Reset
REQ-029 While reset=1 at a clock edge: state=IDLE, FIFO empty, skew registers zero, top_out=0, left_out=0, left_valid=0, weight_WE=0, mux_ctrl=0, done=0, in_ready=0.
REQ-030 Reset mid-WLOAD/STREAM/DRAIN SHALL discard all buffered and in-flight data; in_ready=1 from the first cycle after reset deasserts.

Verification
REQ-031 Weight load: push 4 kind=1 rows 0x0001..0x0004 (all lanes) -> top_out shows 1,2,3,4 on consecutive cycles, weight_WE=1 only with row 4, mux_ctrl=0 throughout.
REQ-032 Skew: push one activation {lane i = 0x10+i}, last=1 -> left_out lane i = 0x10+i with left_valid[i]=1 exactly i+1 cycles after pop; done pulses 1 cycle after DRAIN's 4th bubble.
REQ-033 Backpressure: push 6 vectors back-to-back from IDLE with no pops possible -> in_ready drops after 4 accepted, rises after first pop.
REQ-034 Starvation: stream of 3 activations with one-cycle gap before the last -> bubble with left_valid=0 appears in the skew at the gap position, all lanes.
REQ-035 Reset mid-stream: assert reset 2 cycles into STREAM -> all outputs 0 next cycle, FIFO empty, state IDLE, no done pulse.
